bitmap_wr_ctrl: RTL and testbench

//  Owns the write port of the dual-port video RAM in the etch-a-sketch bitmap path.
//  Two sources share that port: single-pixel pen writes and a full-screen clear sweep.
//  The pen uses a valid/ready handshake; the clear sweep fills every address with CLR_COLOR.

---
 rtl/bitmap_pkg.sv | 15 +
 rtl/bitmap_clr_sweep.sv | 29 ++
 rtl/bitmap_wr_ctrl.sv | 127 ++++++++++++
 tb/tb_bitmap_wr_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitmap_pkg.sv
// Shared constants for the bitmap write path: default geometry, clear colour
// and the write-controller state encoding.
package bitmap_pkg;

    localparam int BM_ADDR_WIDTH = 14;
    localparam int BM_DATA_WIDTH = 3;

    localparam logic [BM_DATA_WIDTH-1:0] BM_CLR_COLOR = 3'b000;

    // WAIT_FRM is only reachable when BITMAP_CLR_VSYNC_EN is defined
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_FRM = 2'd1;
    localparam logic [1:0] ST_CLEAR    = 2'd2;

endpackage

// File: rtl/bitmap_clr_sweep.sv
// Address counter for the full-screen clear sweep; flags the final address.
module bitmap_clr_sweep
    import bitmap_pkg::*;
#(
    parameter int ADDR_WIDTH = BM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] cnt,
    output logic [ADDR_WIDTH-1:0] cnt_inc,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    assign cnt_inc = cnt + ONE;
    assign last    = (cnt == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/bitmap_wr_ctrl.sv
// Arbitrates the video RAM write port between pen writes and the clear sweep.
// Define BITMAP_CLR_VSYNC_EN to hold the sweep start until the next frame_tick.
module bitmap_wr_ctrl
    import bitmap_pkg::*;
#(
    parameter int                    ADDR_WIDTH = BM_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = BM_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLR_COLOR  = DATA_WIDTH'(BM_CLR_COLOR)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pen_valid,
    input  logic [ADDR_WIDTH-1:0] pen_addr,
    input  logic [DATA_WIDTH-1:0] pen_data,
    output logic                  pen_rdy,
    input  logic                  clear_req,
    input  logic                  frame_tick,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  busy,
    output logic                  clr_done_tick
);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  sweep_clr;
    logic                  sweep_en;
    logic                  sweep_last;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_inc;
    logic                  pen_fire;
    logic                  we_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] din_next;

    bitmap_clr_sweep #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_sweep (
        .clk    (clk),
        .reset  (reset),
        .clr    (sweep_clr),
        .en     (sweep_en),
        .cnt    (cnt),
        .cnt_inc(cnt_inc),
        .last   (sweep_last)
    );

    // A clear request on the same cycle as a pen request wins the port
    assign pen_rdy       = (state == ST_IDLE) & ~clear_req;
    assign pen_fire      = pen_valid & pen_rdy;
    assign busy          = (state != ST_IDLE);
    assign clr_done_tick = (state == ST_CLEAR) & sweep_last;

`ifndef BITMAP_CLR_VSYNC_EN
    logic unused_frame_tick;
    assign unused_frame_tick = frame_tick;
`endif

    always_comb begin
        state_next = state;
        sweep_clr  = 1'b0;
        sweep_en   = 1'b0;
        we_next    = 1'b0;
        addr_next  = ram_addr;
        din_next   = ram_din;
        case (state)
            ST_IDLE: begin
                if (clear_req) begin
`ifdef BITMAP_CLR_VSYNC_EN
                    state_next = ST_WAIT_FRM;
`else
                    state_next = ST_CLEAR;
                    sweep_clr  = 1'b1;
                    we_next    = 1'b1;
                    addr_next  = '0;
                    din_next   = CLR_COLOR;
`endif
                end else if (pen_fire) begin
                    we_next   = 1'b1;
                    addr_next = pen_addr;
                    din_next  = pen_data;
                end
            end
`ifdef BITMAP_CLR_VSYNC_EN
            ST_WAIT_FRM: begin
                if (frame_tick) begin
                    state_next = ST_CLEAR;
                    sweep_clr  = 1'b1;
                    we_next    = 1'b1;
                    addr_next  = '0;
                    din_next   = CLR_COLOR;
                end
            end
`endif
            // The output register already shows address cnt; load cnt+1 for the next cycle
            ST_CLEAR: begin
                if (sweep_last) begin
                    state_next = ST_IDLE;
                end else begin
                    sweep_en  = 1'b1;
                    we_next   = 1'b1;
                    addr_next = cnt_inc;
                    din_next  = CLR_COLOR;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            state    <= state_next;
            ram_we   <= we_next;
            ram_addr <= addr_next;
            ram_din  <= din_next;
        end
    end

endmodule

// File: tb/tb_bitmap_wr_ctrl.sv
// Self-checking bench for bitmap_wr_ctrl: vector table, sweep corner cases and
// randomized traffic against a behavioural model of the write port.
module tb_bitmap_wr_ctrl;

    localparam int AW = 14;
    localparam int DW = 3;
    localparam int N  = 1 << AW;
    localparam logic [DW-1:0] CLR = 3'b000;

    logic          clk = 1'b0;
    logic          reset;
    logic          pen_valid;
    logic [AW-1:0] pen_addr;
    logic [DW-1:0] pen_data;
    logic          pen_rdy;
    logic          clear_req;
    logic          frame_tick;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          busy;
    logic          clr_done_tick;

    bitmap_wr_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .pen_valid    (pen_valid),
        .pen_addr     (pen_addr),
        .pen_data     (pen_data),
        .pen_rdy      (pen_rdy),
        .clear_req    (clear_req),
        .frame_tick   (frame_tick),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .busy         (busy),
        .clr_done_tick(clr_done_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: m_pos = -1 idle, -2 waiting for frame, 0..N-1 address on the port now
    int            m_pos = -1;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0;
    logic          model_valid = 1'b0;

    logic          obs_we, obs_rdy, obs_busy, obs_done;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_din;
    logic          clr_tick_rdy;

    typedef struct {
        logic          pv;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        logic          cr;
        logic          e_rdy;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        logic          e_busy;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(logic pv, logic [AW-1:0] pa, logic [DW-1:0] pd, logic cr,
                                logic e_rdy, logic e_we, logic [AW-1:0] e_addr,
                                logic [DW-1:0] e_din, logic e_busy);
        vec_t v;
        v.pv = pv; v.pa = pa; v.pd = pd; v.cr = cr;
        v.e_rdy = e_rdy; v.e_we = e_we; v.e_addr = e_addr; v.e_din = e_din; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_pos = -1; m_we = 1'b0; m_addr = '0; m_din = '0;
            model_valid = 1'b1;
        end else if (m_pos >= 0) begin
            if (m_pos == N - 1) begin
                m_pos = -1; m_we = 1'b0;
            end else begin
                m_pos++; m_we = 1'b1; m_addr = m_pos[AW-1:0]; m_din = CLR;
            end
        end else if (m_pos == -2) begin
            if (frame_tick) begin
                m_pos = 0; m_we = 1'b1; m_addr = '0; m_din = CLR;
            end else begin
                m_we = 1'b0;
            end
        end else if (clear_req) begin
`ifdef BITMAP_CLR_VSYNC_EN
            m_pos = -2; m_we = 1'b0;
`else
            m_pos = 0; m_we = 1'b1; m_addr = '0; m_din = CLR;
`endif
        end else if (pen_valid) begin
            m_we = 1'b1; m_addr = pen_addr; m_din = pen_data;
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic checkModel();
        chk("model_pen_rdy", 32'(pen_rdy), 32'((m_pos == -1) && !clear_req));
        chk("model_busy", 32'(busy), 32'(m_pos != -1));
        chk("model_done", 32'(clr_done_tick), 32'(m_pos == N - 1));
        chk("model_we", 32'(ram_we), 32'(m_we));
        chk("model_addr", 32'(ram_addr), 32'(m_addr));
        chk("model_din", 32'(ram_din), 32'(m_din));
    endtask

    // One clock cycle: sample settled outputs, then advance DUT and model together
    task automatic tick();
        #1;
        obs_we = ram_we; obs_addr = ram_addr; obs_din = ram_din;
        obs_rdy = pen_rdy; obs_busy = busy; obs_done = clr_done_tick;
        if (model_valid) checkModel();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        pen_valid = v.pv; pen_addr = v.pa; pen_data = v.pd; clear_req = v.cr;
        tick();
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        chk($sformatf("vec%0d_rdy", idx), 32'(obs_rdy), 32'(v.e_rdy));
        chk($sformatf("vec%0d_we", idx), 32'(obs_we), 32'(v.e_we));
        chk($sformatf("vec%0d_addr", idx), 32'(obs_addr), 32'(v.e_addr));
        chk($sformatf("vec%0d_din", idx), 32'(obs_din), 32'(v.e_din));
        chk($sformatf("vec%0d_busy", idx), 32'(obs_busy), 32'(v.e_busy));
    endtask

    task automatic start_clear();
        clear_req = 1'b1;
        tick();
        clr_tick_rdy = obs_rdy;
        clear_req = 1'b0;
`ifdef BITMAP_CLR_VSYNC_EN
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
`endif
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int done_cnt, done_i, pen_wr_cnt, pen_i, clears_left;
        logic accepted;

        reset = 1'b1; pen_valid = 1'b0; pen_addr = '0; pen_data = '0;
        clear_req = 1'b0; frame_tick = 1'b0;
        tick();
        tick();
        chk("reset_we", 32'(obs_we), 32'd0);
        chk("reset_addr", 32'(obs_addr), 32'd0);
        chk("reset_din", 32'(obs_din), 32'd0);
        chk("reset_busy", 32'(obs_busy), 32'd0);
        chk("reset_done", 32'(obs_done), 32'd0);
        reset = 1'b0;

        // Pen writes: single, back-to-back, and idle hold of address/data
        vecs[0] = mk(1'b1, 14'h0105, 3'b101, 1'b0, 1'b1, 1'b0, 14'h0000, 3'b000, 1'b0);
        vecs[1] = mk(1'b0, 14'h0000, 3'b000, 1'b0, 1'b1, 1'b1, 14'h0105, 3'b101, 1'b0);
        vecs[2] = mk(1'b1, 14'h3FFF, 3'b111, 1'b0, 1'b1, 1'b0, 14'h0105, 3'b101, 1'b0);
        vecs[3] = mk(1'b1, 14'h0000, 3'b010, 1'b0, 1'b1, 1'b1, 14'h3FFF, 3'b111, 1'b0);
        vecs[4] = mk(1'b0, 14'h0000, 3'b000, 1'b0, 1'b1, 1'b1, 14'h0000, 3'b010, 1'b0);
        vecs[5] = mk(1'b0, 14'h0000, 3'b000, 1'b0, 1'b1, 1'b0, 14'h0000, 3'b010, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        // Full sweep with a pen request held throughout
        start_clear();
        pen_valid = 1'b1; pen_addr = 14'h2A5A; pen_data = 3'b011;
        done_cnt = 0;
        for (int k = 0; k < N; k++) begin
            tick();
            if (obs_we !== 1'b1 || obs_addr !== AW'(k) || obs_din !== CLR || obs_rdy !== 1'b0)
                chk($sformatf("sweep_k%0d", k), {obs_we, obs_rdy, 27'(obs_addr), obs_din},
                    {1'b1, 1'b0, 27'(k), CLR});
            if (obs_done) done_cnt++;
        end
        chk("sweep_last_done", 32'(obs_done), 32'd1);
        chk("sweep_done_count", 32'(done_cnt), 32'd1);
        tick();
        chk("after_sweep_we", 32'(obs_we), 32'd0);
        chk("after_sweep_busy", 32'(obs_busy), 32'd0);
        chk("after_sweep_rdy", 32'(obs_rdy), 32'd1);
        pen_valid = 1'b0;
        tick();
        chk("held_pen_we", 32'(obs_we), 32'd1);
        chk("held_pen_addr", 32'(obs_addr), 32'h2A5A);
        chk("held_pen_din", 32'(obs_din), 32'd3);
        tick();
        chk("held_pen_once", 32'(obs_we), 32'd0);

        // Clear and pen in the same cycle: clear wins, pen lands after the sweep
        pen_valid = 1'b1; pen_addr = 14'h1234; pen_data = 3'b110;
        start_clear();
        chk("tie_rdy", 32'(clr_tick_rdy), 32'd0);
        done_cnt = 0; done_i = -1; pen_wr_cnt = 0; pen_i = -1;
        for (int i = 0; i < N + 6; i++) begin
            tick();
            if (obs_done) begin done_cnt++; done_i = i; end
            if (obs_we && obs_addr == 14'h1234 && obs_din == 3'b110) begin
                pen_wr_cnt++; pen_i = i;
            end
            if (obs_rdy && pen_valid) pen_valid = 1'b0;
        end
        chk("tie_done_count", 32'(done_cnt), 32'd1);
        chk("tie_done_index", 32'(done_i), 32'(N - 1));
        chk("tie_pen_writes", 32'(pen_wr_cnt), 32'd1);
        chk("tie_pen_after_done", 32'(pen_i), 32'(N + 1));

        // Reset in the middle of a sweep aborts it without a done pulse
        start_clear();
        done_cnt = 0;
        for (int k = 0; k < 5000; k++) begin
            tick();
            if (obs_done) done_cnt++;
        end
        reset = 1'b1;
        tick();
        chk("abort_addr", 32'(obs_addr), 32'd5000);
        chk("abort_we", 32'(obs_we), 32'd1);
        reset = 1'b0;
        tick();
        chk("abort_after_we", 32'(obs_we), 32'd0);
        chk("abort_after_busy", 32'(obs_busy), 32'd0);
        chk("abort_after_done", 32'(obs_done), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        start_clear();
        tick();
        chk("restart_we", 32'(obs_we), 32'd1);
        chk("restart_addr", 32'(obs_addr), 32'd0);
        chk("restart_busy", 32'(obs_busy), 32'd1);
        tick();
        chk("restart_addr1", 32'(obs_addr), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

`ifdef BITMAP_CLR_VSYNC_EN
        // Sweep waits for the frame boundary
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (obs_we !== 1'b0 || obs_busy !== 1'b1 || obs_rdy !== 1'b0)
                chk($sformatf("wait_frm_%0d", i), {29'd0, obs_we, obs_busy, obs_rdy}, 32'b010);
        end
        frame_tick = 1'b1;
        tick();
        chk("frame_edge_we", 32'(obs_we), 32'd0);
        chk("frame_edge_busy", 32'(obs_busy), 32'd1);
        frame_tick = 1'b0;
        tick();
        chk("frame_first_we", 32'(obs_we), 32'd1);
        chk("frame_first_addr", 32'(obs_addr), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`endif

        // Random traffic checked only against the model
        clears_left = 1;
        accepted = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (!pen_valid || accepted) begin
                pen_valid = ($urandom_range(0, 1) == 1);
                pen_addr = AW'($urandom);
                pen_data = DW'($urandom_range(0, 7));
            end
            clear_req = 1'b0;
            if (clears_left > 0 && $urandom_range(0, 1999) == 0) begin
                clear_req = 1'b1;
                clears_left--;
            end
            frame_tick = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 799) == 0);
            tick();
            accepted = obs_rdy && pen_valid;
        end
        reset = 1'b1; clear_req = 1'b0; pen_valid = 1'b0; frame_tick = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
